// File: rtl/bnn_popcount_driver.sv
// Sequencer for one fully-connected binary layer: streams activation/weight word pairs into the
// XNOR-popcount unit, accumulates per-neuron partial counts, thresholds them and packs result bits.
module bnn_popcount_driver #(
  parameter int WL      = 112,
  parameter int NWORDS  = 4,
  parameter int NNEURON = 10,
  parameter int ACCW    = 9,
  parameter int WADDRW  = 6,
  parameter int AADDRW  = 2,
  parameter int OADDRW  = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [ACCW-1:0]   iTHRESH,
  output logic [WADDRW-1:0] oW_ADDR,
  input  logic [WL-1:0]     iW_DATA,
  output logic [AADDRW-1:0] oA_ADDR,
  input  logic [WL-1:0]     iA_DATA,
  output logic              oPC_EN,
  output logic [WL-1:0]     oPC_DATA,
  output logic [WL-1:0]     oPC_WEIGHT,
  output logic [2:0]        oPC_STATE,
  output logic [4:0]        oPC_ADDR,
  input  logic [6:0]        iPC_DATA,
  input  logic              iPC_EN,
  output logic              oOUT_WE,
  output logic [OADDRW-1:0] oOUT_ADDR,
  output logic [WL-1:0]     oOUT_DATA,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int NW  = $clog2(NNEURON + 1);
  localparam int BPW = $clog2(WL);

  localparam logic [AADDRW-1:0] W_LAST  = AADDRW'(NWORDS - 1);
  localparam logic [NW-1:0]     N_LAST  = NW'(NNEURON - 1);
  localparam logic [NW-1:0]     N_END   = NW'(NNEURON);
  localparam logic [BPW-1:0]    BP_LAST = BPW'(WL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t              r_state;
  logic [NW-1:0]       r_ni;
  logic [AADDRW-1:0]   r_wi;
  logic [WADDRW-1:0]   r_waddr;
  logic [NW-1:0]       r_nr;
  logic [AADDRW-1:0]   r_wr;
  logic [ACCW-1:0]     r_acc;
  logic [WL-1:0]       r_pack;
  logic [BPW-1:0]      r_bp;
  logic [OADDRW-1:0]   r_ocnt;
  logic                r_pc_en;
  logic                r_out_we;
  logic [OADDRW-1:0]   r_out_addr;
  logic [WL-1:0]       r_out_data;
  logic                r_busy;
  logic                r_done;

  logic                w_rx;
  logic [ACCW-1:0]     w_sum;
  logic                w_bit;
  logic [WL-1:0]       w_pack_nxt;

  // Results are trusted to arrive in issue order; anything beyond the last neuron is dropped.
  assign w_rx  = iPC_EN && (r_state == S_ISSUE || r_state == S_DRAIN) && (r_nr != N_END);
  assign w_sum = ((r_wr == '0) ? '0 : r_acc) + ACCW'(iPC_DATA);
  assign w_bit = (w_sum >= iTHRESH);

  always_comb begin
    w_pack_nxt       = r_pack;
    w_pack_nxt[r_bp] = w_bit;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_ni       <= '0;
      r_wi       <= '0;
      r_waddr    <= '0;
      r_nr       <= '0;
      r_wr       <= '0;
      r_acc      <= '0;
      r_pack     <= '0;
      r_bp       <= '0;
      r_ocnt     <= '0;
      r_pc_en    <= 1'b0;
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pc_en  <= 1'b0;
      r_out_we <= 1'b0;

      if (w_rx) begin
        r_acc <= w_sum;
        if (r_wr == W_LAST) begin
          r_wr <= '0;
          r_nr <= r_nr + NW'(1);
          if (r_bp == BP_LAST) begin
            r_out_we   <= 1'b1;
            r_out_data <= w_pack_nxt;
            r_out_addr <= r_ocnt;
            r_ocnt     <= r_ocnt + OADDRW'(1);
            r_pack     <= '0;
            r_bp       <= '0;
          end else begin
            r_pack <= w_pack_nxt;
            r_bp   <= r_bp + BPW'(1);
          end
        end else begin
          r_wr <= r_wr + AADDRW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          r_ni    <= '0;
          r_wi    <= '0;
          r_waddr <= '0;
          r_nr    <= '0;
          r_wr    <= '0;
          r_pack  <= '0;
          r_bp    <= '0;
          r_ocnt  <= '0;
          if (iSTART) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Read data lands one cycle after the address, together with this flag.
          r_pc_en <= 1'b1;
          if (r_wi == W_LAST) begin
            if (r_ni == N_LAST) begin
              r_state <= S_DRAIN;
            end else begin
              r_wi    <= '0;
              r_ni    <= r_ni + NW'(1);
              r_waddr <= r_waddr + WADDRW'(1);
            end
          end else begin
            r_wi    <= r_wi + AADDRW'(1);
            r_waddr <= r_waddr + WADDRW'(1);
          end
        end
        S_DRAIN: begin
          if (r_nr == N_END) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_bp != '0) begin
            r_out_we   <= 1'b1;
            r_out_data <= r_pack;
            r_out_addr <= r_ocnt;
            r_ocnt     <= r_ocnt + OADDRW'(1);
            r_pack     <= '0;
            r_bp       <= '0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oA_ADDR    = r_wi;
  assign oW_ADDR    = r_waddr;
  assign oPC_EN     = r_pc_en;
  assign oPC_DATA   = iA_DATA;
  assign oPC_WEIGHT = iW_DATA;
  assign oPC_STATE  = 3'b011;
  assign oPC_ADDR   = 5'd0;
  assign oOUT_WE    = r_out_we;
  assign oOUT_ADDR  = r_out_addr;
  assign oOUT_DATA  = r_out_data;
  assign oBUSY      = r_busy;
  assign oDONE      = r_done;

endmodule
